// File: rtl/seq_mult_core.sv
// Sequential multiplier: one add/shift step per cycle, unsigned or radix-2 Booth.
// start/busy/done handshake with abort; result is registered and held until the next completed operation.
module seq_mult_core #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH+1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    state_e               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       mext;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       step_a;
    logic [WIDTH-1:0]     step_q;

    // One datapath step; the extra A bit absorbs the unsigned carry and the Booth -2^(W-1) case.
    always_comb begin
        mext = {m_q[WIDTH-1] & mode_q, m_q};
        sum  = a_q;
        if (mode_q) begin
            case ({q_q[0], qm1_q})
                2'b01:   sum = a_q + mext;
                2'b10:   sum = a_q - mext;
                default: sum = a_q;
            endcase
        end else if (q_q[0]) begin
            sum = a_q + mext;
        end
        step_a = {mode_q & sum[WIDTH], sum[WIDTH:1]};
        step_q = {sum[0], q_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    mode_d  = signed_mode;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    a_d   = step_a;
                    q_d   = step_q;
                    qm1_d = q_q[0];
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        prod_d  = {step_a[WIDTH-1:0], step_q};
                    end
                end
            end
            default: begin
                state_d = IDLE;
                a_d     = '0;
                q_d     = '0;
                qm1_d   = 1'b0;
                m_d     = '0;
                cnt_d   = '0;
                mode_d  = 1'b0;
                prod_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == LOAD) || (state_q == RUN);
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_seq_mult_core.sv
// Bench for seq_mult_core: WIDTH=16 directed/random cases and an exhaustive WIDTH=4 sweep,
// checked against an arithmetic reference product.
module tb_seq_mult_core;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start16, smode16, abort16;
    logic [15:0] m16, q16;
    logic        busy16, done16;
    logic [31:0] prod16;

    logic        start4, smode4, abort4;
    logic [3:0]  m4, q4;
    logic        busy4, done4;
    logic [7:0]  prod4;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;

    seq_mult_core #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(smode16), .abort(abort16),
        .multiplicand(m16), .multiplier(q16), .busy(busy16), .done(done16), .product(prod16)
    );

    seq_mult_core #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(smode4), .abort(abort4),
        .multiplicand(m4), .multiplier(q4), .busy(busy4), .done(done4), .product(prod4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference product: plain integer multiply of the (optionally sign-extended) operands.
    function automatic longint ref_mul(input longint m, input longint q, input int w, input bit md);
        longint ms, qs, half, full;
        half = longint'(1) << (w - 1);
        full = longint'(1) << w;
        ms = (md && m >= half) ? m - full : m;
        qs = (md && q >= half) ? q - full : q;
        return (ms * qs) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Start is accepted on the edge inside this task; t0 marks that edge.
    // Operands are scrambled right after acceptance, which must not disturb the result.
    task automatic launch(input int w, input logic [15:0] m, input logic [15:0] q, input bit md);
        if (w == 16) begin
            m16 = m; q16 = q; smode16 = md; start16 = 1'b1;
        end else begin
            m4 = m[3:0]; q4 = q[3:0]; smode4 = md; start4 = 1'b1;
        end
        tick();
        t0 = cyc;
        start16 = 1'b0; start4 = 1'b0;
        m16 = 16'($urandom); q16 = 16'($urandom); smode16 = 1'($urandom);
        m4  = 4'($urandom);  q4  = 4'($urandom);  smode4  = 1'($urandom);
    endtask

    // The cycle following edge t counts as cycle t+1, so done must be seen in cycle t0+w+2.
    task automatic wait_done(input int w, input string tag, input logic [31:0] exp, input bit chk_busy);
        int nb;
        nb = 0;
        while (!(w == 16 ? done16 : done4) && (cyc - t0) < 60) begin
            if (w == 16 ? busy16 : busy4) nb++;
            tick();
        end
        chk({tag, "_lat"}, 64'(cyc - t0 + 1), 64'(w + 2));
        if (w == 16) chk({tag, "_prod"}, 64'(prod16), 64'(exp));
        else         chk({tag, "_prod"}, 64'(prod4), 64'(exp[7:0]));
        if (chk_busy) chk({tag, "_busycyc"}, 64'(nb), 64'(w + 1));
    endtask

    initial begin
        logic [31:0] last;
        rst_n = 1'b0;
        start16 = 0; smode16 = 0; abort16 = 0; m16 = '0; q16 = '0;
        start4  = 0; smode4  = 0; abort4  = 0; m4  = '0; q4  = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_busy", 64'(busy16), 64'd0);
        chk("rst_done", 64'(done16), 64'd0);
        chk("rst_prod", 64'(prod16), 64'd0);
        chk("rst_prod4", 64'(prod4), 64'd0);
        tick();

        // Unsigned maximum
        launch(16, 16'hFFFF, 16'hFFFF, 1'b0);
        wait_done(16, "umax", 32'hFFFE0001, 1'b1);
        tick();
        chk("done_single", 64'(done16), 64'd0);
        chk("done_hold", 64'(prod16), 64'hFFFE0001);

        // Signed corner cases, launched back-to-back from DONE
        launch(16, 16'hFFFD, 16'h0005, 1'b1);
        wait_done(16, "s_m3x5", 32'hFFFFFFF1, 1'b1);
        launch(16, 16'h8000, 16'h8000, 1'b1);
        wait_done(16, "s_minxmin", 32'h40000000, 1'b0);
        launch(16, 16'h8000, 16'h7FFF, 1'b1);
        wait_done(16, "s_minxmax", 32'hC0008000, 1'b0);

        // Start during RUN is ignored
        launch(16, 16'h00AB, 16'h0107, 1'b0);
        tick(); tick(); tick();
        m16 = 16'h0101; q16 = 16'h0202; smode16 = 1'b1; start16 = 1'b1;
        tick(); tick();
        start16 = 1'b0;
        wait_done(16, "ign_start", 32'(ref_mul(64'h00AB, 64'h0107, 16, 1'b0)), 1'b0);

        // Back-to-back from DONE; old product held until the final step
        last = prod16;
        tick();
        launch(16, 16'h0003, 16'h0004, 1'b0);
        chk("b2b_busy", 64'(busy16), 64'd1);
        chk("b2b_hold", 64'(prod16), 64'(last));
        wait_done(16, "b2b", 32'h0000000C, 1'b0);

        // Abort in the 5th RUN cycle
        last = prod16;
        launch(16, 16'h1234, 16'h5678, 1'b0);
        repeat (5) tick();
        abort16 = 1'b1;
        tick();
        abort16 = 1'b0;
        chk("abort_busy", 64'(busy16), 64'd0);
        chk("abort_done", 64'(done16), 64'd0);
        chk("abort_prod", 64'(prod16), 64'(last));
        begin
            int seen;
            seen = 0;
            repeat (25) begin
                tick();
                if (done16) seen++;
            end
            chk("abort_nodone", 64'(seen), 64'd0);
        end

        // Reset mid-RUN
        launch(16, 16'h1234, 16'h5678, 1'b1);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_busy", 64'(busy16), 64'd0);
        chk("mrst_done", 64'(done16), 64'd0);
        chk("mrst_prod", 64'(prod16), 64'd0);
        tick();
        launch(16, 16'h0002, 16'h0002, 1'b0);
        wait_done(16, "post_rst", 32'h00000004, 1'b1);

        // Random WIDTH=16 operations
        repeat (20) begin
            logic [15:0] rm, rq;
            bit rmd;
            rm = 16'($urandom); rq = 16'($urandom); rmd = 1'($urandom);
            launch(16, rm, rq, rmd);
            wait_done(16, rmd ? "rnd_s" : "rnd_u", 32'(ref_mul(64'(rm), 64'(rq), 16, rmd)), 1'b0);
        end

        // Exhaustive WIDTH=4 sweep, both modes
        for (int md = 0; md < 2; md++) begin
            for (int mi = 0; mi < 16; mi++) begin
                for (int qi = 0; qi < 16; qi++) begin
                    launch(4, 16'(mi), 16'(qi), 1'(md));
                    wait_done(4, md ? "w4_s" : "w4_u", 32'(ref_mul(longint'(mi), longint'(qi), 4, 1'(md))), 1'b0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
